// File: rtl/exec_sequencer.sv
// mypicoMIPS multi-cycle control sequencer.
// Fetch/execute stepping with LD switch handshake and MUL latency stall.
module exec_sequencer #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             flag,
  input  logic             sw_valid,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_rel,
  output logic             reg_we,
  output logic             imm_sel,
  output logic [2:0]       alu_func,
  output logic             sw_ack,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_BNE  = 3'd6;

  localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MUL,
    S_LDWAIT,
    S_LDREL
  } state_t;

  state_t     state;
  state_t     nxt;
  logic [3:0] cnt;

  assign nxt = run ? S_FETCH : S_IDLE;

  always_comb begin
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    pc_rel   = 1'b0;
    reg_we   = 1'b0;
    imm_sel  = 1'b0;
    alu_func = 3'd0;
    sw_ack   = 1'b0;
    illegal  = 1'b0;
    busy     = (state != S_IDLE);
    unique case (state)
      S_FETCH: ir_load = 1'b1;
      S_EXEC: begin
        alu_func = opcode;
        case (opcode)
          OP_ADD: begin
            reg_we = 1'b1;
            pc_en  = 1'b1;
          end
          OP_ADDI: begin
            reg_we  = 1'b1;
            imm_sel = 1'b1;
            pc_en   = 1'b1;
          end
          OP_BEQ: begin
            pc_en  = 1'b1;
            pc_rel = flag;
          end
          OP_BNE: begin
            pc_en  = 1'b1;
            pc_rel = ~flag;
          end
          OP_LD:  ;
          OP_MUL: imm_sel = 1'b1;
          default: begin
            illegal = 1'b1;
            pc_en   = 1'b1;
          end
        endcase
      end
      S_MUL: begin
        alu_func = OP_MUL;
        imm_sel  = 1'b1;
        if (cnt == 4'd0) begin
          reg_we = 1'b1;
          pc_en  = 1'b1;
        end
      end
      S_LDWAIT: begin
        if (sw_valid) begin
          reg_we = 1'b1;
          sw_ack = 1'b1;
          pc_en  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      retired <= '0;
    end else begin
      if (pc_en) retired <= retired + CNT_W'(1);
      unique case (state)
        S_IDLE:  if (run) state <= S_FETCH;
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (opcode)
            OP_LD:  state <= S_LDWAIT;
            OP_MUL: begin
              cnt   <= MUL_INIT;
              state <= S_MUL;
            end
            default: state <= nxt;
          endcase
        end
        S_MUL: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else state <= nxt;
        end
        S_LDWAIT: if (sw_valid) state <= S_LDREL;
        // Hold until the button is released so one press is one LD.
        S_LDREL:  if (!sw_valid) state <= nxt;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer.
// Per-instruction cycle model derived from the opcode step table.
module tb_exec_sequencer;

  localparam int MUL_LAT = 4;
  localparam int CNT_W   = 8;

  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ADDI = 3'd3;
  localparam logic [2:0] OP_MUL  = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_BNE  = 3'd6;

  logic             clk;
  logic             reset_n;
  logic             run;
  logic [2:0]       opcode;
  logic             flag;
  logic             sw_valid;
  logic             ir_load;
  logic             pc_en;
  logic             pc_rel;
  logic             reg_we;
  logic             imm_sel;
  logic [2:0]       alu_func;
  logic             sw_ack;
  logic             busy;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  int ntest;
  int nfail;
  int exp_ret;

  exec_sequencer #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .opcode(opcode),
    .flag(flag),
    .sw_valid(sw_valid),
    .ir_load(ir_load),
    .pc_en(pc_en),
    .pc_rel(pc_rel),
    .reg_we(reg_we),
    .imm_sel(imm_sel),
    .alu_func(alu_func),
    .sw_ack(sw_ack),
    .busy(busy),
    .illegal(illegal),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] o;
  assign o = {ir_load, pc_en, pc_rel, reg_we, imm_sel,
              alu_func, sw_ack, busy, illegal};

  function automatic logic [10:0] mk(
    input logic ir, input logic pce, input logic rel,
    input logic we, input logic imm, input logic [2:0] fn,
    input logic ack, input logic bsy, input logic ill);
    return {ir, pce, rel, we, imm, fn, ack, bsy, ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    run      = 1'b0;
    opcode   = 3'd0;
    flag     = 1'b0;
    sw_valid = 1'b0;
    tick();
    repeat (3) begin
      run = 1'b1;
      sw_valid = 1'b1;
      #1;
      ntest++;
      if (o !== 11'd0 || retired !== '0) begin
        nfail++;
        $display("FAIL reset outs=%b ret=%0d exp outs=0 ret=0",
                 o, retired);
      end
      tick();
    end
    run = 1'b0;
    sw_valid = 1'b0;
    reset_n = 1'b1;
    exp_ret = 0;
    tick();
  endtask

  task automatic start();
    run = 1'b1;
    #1;
    ntest++;
    if (o !== 11'd0) begin
      nfail++;
      $display("FAIL idle_start outs=%b exp=%b", o, 11'd0);
    end
    tick();
  endtask

  // Runs one instruction from its FETCH cycle to completion.
  task automatic exec_one(input logic [2:0] op, input logic fl,
                          input logic ra, input int wt, input int hd);
    logic [10:0] e;
    int we_cnt;
    logic last;
    opcode = op;
    flag = fl;
    sw_valid = 1'b0;
    run = 1'b1;
    #1;
    e = mk(1, 0, 0, 0, 0, 3'd0, 0, 1, 0);
    ntest++;
    if (o !== e) begin
      nfail++;
      $display("FAIL fetch op=%0d got=%b exp=%b", op, o, e);
    end
    tick();
    run = ra;
    #1;
    case (op)
      OP_ADD:  e = mk(0, 1, 0, 1, 0, op, 0, 1, 0);
      OP_ADDI: e = mk(0, 1, 0, 1, 1, op, 0, 1, 0);
      OP_BEQ:  e = mk(0, 1, fl, 0, 0, op, 0, 1, 0);
      OP_BNE:  e = mk(0, 1, !fl, 0, 0, op, 0, 1, 0);
      OP_LD:   e = mk(0, 0, 0, 0, 0, op, 0, 1, 0);
      OP_MUL:  e = mk(0, 0, 0, 0, 1, op, 0, 1, 0);
      default: e = mk(0, 1, 0, 0, 0, op, 0, 1, 1);
    endcase
    ntest++;
    if (o !== e) begin
      nfail++;
      $display("FAIL exec op=%0d fl=%0d got=%b exp=%b", op, fl, o, e);
    end
    if (e[9]) exp_ret++;
    tick();
    if (op == OP_MUL) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        #1;
        last = (i == MUL_LAT - 1);
        e = mk(0, last, 0, last, 1, OP_MUL, 0, 1, 0);
        ntest++;
        if (o !== e) begin
          nfail++;
          $display("FAIL mul_step%0d got=%b exp=%b", i, o, e);
        end
        if (last) exp_ret++;
        tick();
      end
    end
    if (op == OP_LD) begin
      we_cnt = 0;
      e = mk(0, 0, 0, 0, 0, 3'd0, 0, 1, 0);
      for (int i = 0; i < wt; i++) begin
        #1;
        we_cnt += int'(reg_we);
        ntest++;
        if (o !== e) begin
          nfail++;
          $display("FAIL ld_wait%0d got=%b exp=%b", i, o, e);
        end
        tick();
      end
      sw_valid = 1'b1;
      #1;
      we_cnt += int'(reg_we);
      ntest++;
      if (o !== mk(0, 1, 0, 1, 0, 3'd0, 1, 1, 0)) begin
        nfail++;
        $display("FAIL ld_ack got=%b exp=%b", o,
                 mk(0, 1, 0, 1, 0, 3'd0, 1, 1, 0));
      end
      exp_ret++;
      tick();
      for (int i = 0; i < hd; i++) begin
        #1;
        we_cnt += int'(reg_we);
        ntest++;
        if (o !== e) begin
          nfail++;
          $display("FAIL ld_rel%0d got=%b exp=%b", i, o, e);
        end
        tick();
      end
      sw_valid = 1'b0;
      #1;
      we_cnt += int'(reg_we);
      ntest++;
      if (o !== e || we_cnt !== 1) begin
        nfail++;
        $display("FAIL ld_done got=%b exp=%b we_pulses=%0d exp=1",
                 o, e, we_cnt);
      end
      tick();
    end
    #1;
    ntest++;
    if (retired !== CNT_W'(exp_ret)) begin
      nfail++;
      $display("FAIL retired op=%0d got=%0d exp=%0d",
               op, retired, CNT_W'(exp_ret));
    end
    if (!ra) begin
      ntest++;
      if (o !== 11'd0) begin
        nfail++;
        $display("FAIL to_idle op=%0d got=%b exp=%b", op, o, 11'd0);
      end
    end
  endtask

  task automatic test_add();
    test_reset();
    start();
    exec_one(OP_ADD, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_branch();
    start();
    exec_one(OP_BEQ, 1'b1, 1'b1, 0, 0);
    exec_one(OP_BEQ, 1'b0, 1'b1, 0, 0);
    exec_one(OP_BNE, 1'b1, 1'b1, 0, 0);
    exec_one(OP_BNE, 1'b0, 1'b1, 0, 0);
    exec_one(OP_ADDI, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_mul();
    start();
    exec_one(OP_MUL, 1'b0, 1'b1, 0, 0);
    exec_one(OP_MUL, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_ld();
    start();
    exec_one(OP_LD, 1'b0, 1'b0, 10, 4);
  endtask

  task automatic test_illegal();
    start();
    exec_one(3'd0, 1'b0, 1'b1, 0, 0);
    exec_one(3'd7, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_idle_ignore();
    run = 1'b0;
    repeat (6) begin
      sw_valid = 1'($urandom_range(0, 1));
      opcode = 3'($urandom_range(0, 7));
      #1;
      ntest++;
      if (o !== 11'd0 || retired !== CNT_W'(exp_ret)) begin
        nfail++;
        $display("FAIL idle_hold outs=%b ret=%0d exp outs=0 ret=%0d",
                 o, retired, CNT_W'(exp_ret));
      end
      tick();
    end
    sw_valid = 1'b0;
  endtask

  task automatic test_reset_ldwait();
    start();
    opcode = OP_LD;
    sw_valid = 1'b0;
    tick();
    tick();
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    sw_valid = 1'b1;
    #1;
    ntest++;
    if (o !== 11'd0 || retired !== '0) begin
      nfail++;
      $display("FAIL reset_ldwait outs=%b ret=%0d exp outs=0 ret=0",
               o, retired);
    end
    tick();
    run = 1'b0;
    sw_valid = 1'b0;
    reset_n = 1'b1;
    exp_ret = 0;
    tick();
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic ra;
    start();
    for (int i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) != 0);
      exec_one(op, 1'($urandom_range(0, 1)), ra,
               $urandom_range(0, 5), $urandom_range(0, 4));
      if (!ra) start();
    end
    exec_one(OP_ADD, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_wrap();
    test_reset();
    start();
    for (int i = 0; i < 256; i++)
      exec_one(OP_ADDI, 1'b0, (i != 255), 0, 0);
    ntest++;
    if (retired !== '0) begin
      nfail++;
      $display("FAIL wrap got=%0d exp=0", retired);
    end
  endtask

  initial begin
    ntest = 0;
    nfail = 0;
    exp_ret = 0;
    test_reset();
    test_add();
    test_branch();
    test_mul();
    test_ld();
    test_illegal();
    test_idle_ignore();
    test_reset_ldwait();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
